// File: rtl/sort_controller.sv
// Control FSM for an in-place exchange sort over a K-entry memory with A/B registers and i/j indices.
// Optional swap counter output is built only when SORT_SWAP_CNT_EN is defined.
module sort_controller #(
  parameter int SWAP_CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic AgtB,
  input  logic zi,
  input  logic zj,
  output logic EA,
  output logic EB,
  output logic Li,
  output logic Ei,
  output logic Lj,
  output logic Ej,
  output logic Csel,
  output logic WE,
  output logic Bout,
  output logic busy,
  output logic done
`ifdef SORT_SWAP_CNT_EN
  ,
  output logic [SWAP_CNT_W-1:0] swap_count
`endif
);

  typedef enum logic [3:0] {
    IDLE, INIT_I, LOAD_A, LOAD_B, CMP, SWAP_I, SWAP_J, RELOAD_A, NEXT_J, NEXT_I, DONE
  } state_t;

  state_t state;
  state_t nxt;
  logic   nj_q;
  logic   ni_q;

  function automatic state_t next_of(state_t s, logic st, logic agt, logic zi_i, logic zj_i);
    state_t n;
    n = s;
    case (s)
      IDLE:     n = st ? INIT_I : IDLE;
      INIT_I:   n = LOAD_A;
      LOAD_A:   n = LOAD_B;
      LOAD_B:   n = CMP;
      CMP:      n = agt ? SWAP_I : NEXT_J;
      SWAP_I:   n = SWAP_J;
      SWAP_J:   n = RELOAD_A;
      RELOAD_A: n = NEXT_J;
      NEXT_J:   n = zj_i ? NEXT_I : LOAD_B;
      NEXT_I:   n = zi_i ? DONE : LOAD_A;
      DONE:     n = st ? DONE : IDLE;
      default:  n = IDLE;
    endcase
    return n;
  endfunction

  assign nxt = next_of(state, start, AgtB, zi, zj);

  // Strobes are decoded from the upcoming state so each is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      EA    <= 1'b0;
      EB    <= 1'b0;
      Li    <= 1'b0;
      Lj    <= 1'b0;
      Csel  <= 1'b0;
      WE    <= 1'b0;
      Bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      nj_q  <= 1'b0;
      ni_q  <= 1'b0;
    end else begin
      state <= nxt;
      EA    <= (nxt == LOAD_A) || (nxt == RELOAD_A);
      EB    <= (nxt == LOAD_B);
      Li    <= (nxt == INIT_I);
      Lj    <= (nxt == LOAD_A);
      Csel  <= (nxt == LOAD_B) || (nxt == SWAP_J);
      WE    <= (nxt == SWAP_I) || (nxt == SWAP_J);
      Bout  <= (nxt == SWAP_I);
      busy  <= (nxt != IDLE) && (nxt != DONE);
      done  <= (nxt == DONE);
      nj_q  <= (nxt == NEXT_J);
      ni_q  <= (nxt == NEXT_I);
    end
  end

  // The index increments depend on the live end-of-range flags seen in the same state.
  assign Ej = nj_q & ~zj;
  assign Ei = ni_q & ~zi;

`ifdef SORT_SWAP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_count <= '0;
    end else if (nxt == INIT_I) begin
      swap_count <= '0;
    end else if ((state == SWAP_J) && (swap_count != {SWAP_CNT_W{1'b1}})) begin
      swap_count <= swap_count + SWAP_CNT_W'(1);
    end
  end
`endif

endmodule
